// File: rtl/iter_div.sv
// Iterative 32-bit radix-2 restoring divider with valid/ready operand handshake.
// Optional ITER_DIV_ZERO_BYPASS_EN: a zero divisor skips CALC/SIGN and goes straight to DONE.
module iter_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_signed,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  input  logic [31:0] s_axis_divisor_tdata,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  output logic [63:0] m_axis_dout_tdata,
  output logic        m_axis_dout_tvalid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic        sign_a_r;
  logic        sign_b_r;
  logic [31:0] quo_r;
  logic [31:0] dvs_r;
  logic [31:0] rem_r;
  logic [31:0] raw_r;
  logic [5:0]  cnt_r;

  logic        accept_s;
  logic        sa_s;
  logic        sb_s;
  logic [32:0] shifted_s;
  logic [32:0] trial_s;
  logic [31:0] q_fin_s;
  logic [31:0] r_fin_s;

  function automatic logic [31:0] abs_val(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    if (neg) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign s_axis_dividend_tready = (state_r == IDLE);
  assign s_axis_divisor_tready  = (state_r == IDLE);

  // Handshake decode, operand signs and one restoring step.
  always_comb begin
    accept_s  = (state_r == IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
    sa_s      = div_signed & s_axis_dividend_tdata[31];
    sb_s      = div_signed & s_axis_divisor_tdata[31];
    shifted_s = {rem_r, quo_r[31]};
    trial_s   = shifted_s - {1'b0, dvs_r};
  end

  // Final sign fix-up; a zero divisor forces the all-ones quotient and raw dividend.
  always_comb begin
    q_fin_s = quo_r;
    r_fin_s = rem_r;
    if (dvs_r == 32'd0) begin
      q_fin_s = 32'hFFFF_FFFF;
      r_fin_s = raw_r;
    end else begin
      if (sign_a_r ^ sign_b_r) begin
        q_fin_s = ~quo_r + 32'd1;
      end else begin
        q_fin_s = quo_r;
      end
      if (sign_a_r) begin
        r_fin_s = ~rem_r + 32'd1;
      end else begin
        r_fin_s = rem_r;
      end
    end
  end

  // Control FSM with datapath registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r            <= IDLE;
      sign_a_r           <= 1'b0;
      sign_b_r           <= 1'b0;
      quo_r              <= 32'd0;
      dvs_r              <= 32'd0;
      rem_r              <= 32'd0;
      raw_r              <= 32'd0;
      cnt_r              <= 6'd0;
      m_axis_dout_tdata  <= 64'd0;
      m_axis_dout_tvalid <= 1'b0;
    end else begin
      m_axis_dout_tvalid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            sign_a_r <= sa_s;
            sign_b_r <= sb_s;
            quo_r    <= abs_val(s_axis_dividend_tdata, sa_s);
            dvs_r    <= abs_val(s_axis_divisor_tdata, sb_s);
            raw_r    <= s_axis_dividend_tdata;
            rem_r    <= 32'd0;
            cnt_r    <= 6'd0;
`ifdef ITER_DIV_ZERO_BYPASS_EN
            if (s_axis_divisor_tdata == 32'd0) begin
              m_axis_dout_tdata  <= {32'hFFFF_FFFF, s_axis_dividend_tdata};
              m_axis_dout_tvalid <= 1'b1;
              state_r            <= DONE;
            end else begin
              state_r <= CALC;
            end
`else
            state_r <= CALC;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          // Dividend bits shift out of quo_r's MSB while quotient bits enter at the LSB.
          if (!trial_s[32]) begin
            rem_r <= trial_s[31:0];
            quo_r <= {quo_r[30:0], 1'b1};
          end else begin
            rem_r <= shifted_s[31:0];
            quo_r <= {quo_r[30:0], 1'b0};
          end
          cnt_r <= cnt_r + 6'd1;
          if (cnt_r == 6'd31) begin
            state_r <= SIGN;
          end else begin
            state_r <= CALC;
          end
        end
        SIGN: begin
          m_axis_dout_tdata  <= {q_fin_s, r_fin_s};
          m_axis_dout_tvalid <= 1'b1;
          state_r            <= DONE;
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Scoreboard bench for iter_div: stimulus pushes expected results, a monitor pops and checks them.
module tb_iter_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_signed;
  logic [31:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic [63:0] dout;
  logic        dout_valid;

  iter_div dut (
    .clk                    (clk),
    .reset                  (reset),
    .div_signed             (div_signed),
    .s_axis_dividend_tdata  (a_data),
    .s_axis_dividend_tvalid (a_valid),
    .s_axis_dividend_tready (a_ready),
    .s_axis_divisor_tdata   (b_data),
    .s_axis_divisor_tvalid  (b_valid),
    .s_axis_divisor_tready  (b_ready),
    .m_axis_dout_tdata      (dout),
    .m_axis_dout_tvalid     (dout_valid)
  );

  always #5 clk = ~clk;

`ifdef ITER_DIV_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 34;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] data;
    int          cyc;
    string       name;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && dout_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got tdata %h with no result expected", dout);
      end else begin
        e = sb.pop_front();
        check({e.name, "_data"}, dout, e.data);
        check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_ready(input string name);
    int k = 0;
    while (a_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_ready_timeout: got ready %b expected 1", name, a_ready);
    end
  endtask

  // Presents a pair at a negedge (cycle 0); returns at the negedge of cycle 1.
  task automatic issue(input string name, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int lat, input bit push);
    wait_ready(name);
    div_signed = sgn;
    a_data     = a;
    b_data     = b;
    a_valid    = 1'b1;
    b_valid    = 1'b1;
    if (push) sb.push_back('{exp, cyc + lat, name});
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    div_signed = 1'b0;
    a_data     = 32'd0;
    b_data     = 32'd0;
    a_valid    = 1'b0;
    b_valid    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tdata", dout, 64'd0);
    check("reset_tvalid", {63'd0, dout_valid}, 64'd0);
    check("reset_tready", {62'd0, a_ready, b_ready}, 64'd3);
    reset = 1'b0;
    @(negedge clk);

    // Unsigned 100 / 7 with busy-window ready checks.
    issue("u100_7", 1'b0, 32'd100, 32'd7, 64'h0000000E_00000002, 34, 1'b1);
    for (int i = 1; i <= 34; i++) begin
      check("busy_tready", {62'd0, a_ready, b_ready}, 64'd0);
      @(negedge clk);
    end
    check("tready_back_c35", {62'd0, a_ready, b_ready}, 64'd3);

    issue("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFD_FFFFFFFF, 34, 1'b1);
    issue("s_7_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'hFFFFFFFD_00000001, 34, 1'b1);
    issue("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 34, 1'b1);
    issue("u_ovf", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 1'b1);
    issue("u_div0", 1'b0, 32'h00001234, 32'h00000000, 64'hFFFFFFFF_00001234, ZLAT, 1'b1);
    issue("s_div0", 1'b1, 32'hFFFFFFF0, 32'h00000000, 64'hFFFFFFFF_FFFFFFF0, ZLAT, 1'b1);

    // Only the dividend valid: nothing may be accepted.
    wait_ready("half");
    div_signed = 1'b0;
    a_data     = 32'd20;
    b_data     = 32'd3;
    a_valid    = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("half_valid_tready", {62'd0, a_ready, b_ready}, 64'd3);
    end
    b_valid = 1'b1;
    sb.push_back('{64'h00000006_00000002, cyc + 34, "u20_3"});
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    check("half_then_accept", {62'd0, a_ready, b_ready}, 64'd0);

    // Abort a divide with reset in cycle 10; no pulse may follow.
    issue("abort", 1'b0, 32'hFFFFFFFF, 32'd7, 64'd0, 34, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_tdata", dout, 64'd0);
    check("abort_tvalid", {63'd0, dout_valid}, 64'd0);
    check("abort_tready", {62'd0, a_ready, b_ready}, 64'd3);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_pulse_tdata", dout, 64'd0);

    issue("u_ffff_10", 1'b0, 32'hFFFFFFFF, 32'h00000010, 64'h0FFFFFFF_0000000F, 34, 1'b1);

    begin
      int k = 0;
      while (sb.size() != 0 && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_div.md
# iter_div

Iterative 32-bit radix-2 restoring divider serving as the responder for the EX stage's divide handshake. It accepts a dividend/divisor pair over AXI-stream-style valid/ready channels and computes quotient and remainder over multiple cycles. It returns the result as a one-cycle valid pulse on a 64-bit output word, {quotient, remainder}. The EX stage instantiates it twice, with `div_signed` tied 1 for div.w/mod.w and tied 0 for div.wu/mod.wu, and stalls on the output valid.

## Interface
Parameters:
- None. Data width is fixed at 32 bits for operands and 64 bits for the result.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `div_signed`  in  1  1 = two's-complement divide, 0 = unsigned; sampled at acceptance
- `s_axis_dividend_tdata`  in  32  dividend
- `s_axis_dividend_tvalid`  in  1  dividend valid
- `s_axis_dividend_tready`  out  1  divider can accept dividend
- `s_axis_divisor_tdata`  in  32  divisor
- `s_axis_divisor_tvalid`  in  1  divisor valid
- `s_axis_divisor_tready`  out  1  divider can accept divisor
- `m_axis_dout_tdata`  out  64  [63:32] quotient, [31:0] remainder
- `m_axis_dout_tvalid`  out  1  result valid; one-cycle pulse, no back-pressure

## Operation
- States: IDLE, CALC, SIGN, DONE. Reset enters IDLE.
- Both tready outputs equal (state == IDLE). They are always identical.
- Acceptance:
  - Occurs on an edge where state == IDLE and both tvalid are high.
  - If only one tvalid is high, nothing is accepted and the other channel is not latched.
- At acceptance the block latches:
  - `div_signed`;
  - operand signs (a31 & signed, b31 & signed);
  - absolute values: the two's-complement negation when the sign is set, otherwise the raw value;
  - clears the 32-bit partial remainder and the 6-bit iteration counter.
- CALC, 32 iterations, MSB first:
  - trial = {rem, next dividend bit} − divisor_abs, computed at 33 bits;
  - if non-negative: rem = trial and shift in quotient bit 1;
  - otherwise: rem = shifted value and shift in quotient bit 0;
  - counter 31 → next state SIGN.
- SIGN:
  - quotient is negated if sign_a ^ sign_b;
  - remainder is negated if sign_a, so the remainder takes the dividend's sign;
  - result is written into `m_axis_dout_tdata`; next state DONE.
- DONE: `m_axis_dout_tvalid` = 1 for exactly this cycle; next state IDLE.
- `m_axis_dout_tdata` holds its value until the next SIGN (or zero-divisor) update; it is not cleared on return to IDLE.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No exception is raised.
- Divide by zero, signed or unsigned:
  - result is quotient 0xFFFFFFFF, remainder = dividend as presented, unmodified;
  - SIGN forces these values whenever the latched divisor is zero, so the result is identical with or without the configuration macro.

## Timing
- Reset values: `m_axis_dout_tvalid` 0, `m_axis_dout_tdata` 0, both tready 1 (state IDLE), iteration counter 0.
- Latency, counting the acceptance cycle as cycle 0:
  - CALC occupies cycles 1–32;
  - SIGN is cycle 33;
  - `m_axis_dout_tvalid` is high in cycle 34 only;
  - tready returns high in cycle 35.
- Throughput: one division per 35 cycles. There is no pipelining or operand queueing.
- tvalid held across the busy period: the next acceptance happens in cycle 35 at the earliest. The producer deasserts tvalid itself; the block never re-accepts a pair it has already consumed.
- Reset asserted in any state: on the next edge state = IDLE, tvalid = 0, tdata = 0, tready = 1. No result pulse is emitted for the aborted operation.
- Reset and tvalid high on the same edge: reset wins and nothing is accepted.

## Configuration
- `ITER_DIV_ZERO_BYPASS_EN` defined:
  - a zero divisor at acceptance skips CALC and SIGN;
  - the result {0xFFFFFFFF, dividend} is written on the acceptance edge and the state goes directly to DONE;
  - `m_axis_dout_tvalid` is high in cycle 1 and tready is high again in cycle 2.
- Undefined: a zero divisor takes the full 34-cycle path, with identical result data.

## Test plan
- Unsigned 100 / 7, dividends and divisors presented in cycle 0 → tvalid in cycle 34 only, tdata = 0x0000000E_00000002, tready low cycles 1–34.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → tdata = 0xFFFFFFFD_FFFFFFFF. Signed 7 / −2 → 0xFFFFFFFD_00000001.
- Signed 0x80000000 / 0xFFFFFFFF → 0x80000000_00000000. The same operands unsigned → 0x00000000_80000000.
- Dividend 0x00001234, divisor 0 → tdata 0xFFFFFFFF_00001234:
  - with the macro, tvalid in cycle 1;
  - without the macro, tvalid in cycle 34.
- Only the dividend tvalid high for 5 cycles → no acceptance and both tready stay 1. Then assert the divisor tvalid → acceptance on that edge.
- Assert reset in cycle 10 of a divide → IDLE next cycle, tdata = 0, no tvalid pulse. A following 0xFFFFFFFF / 0x10 unsigned → 0x0FFFFFFF_0000000F.
